// File: rtl/cmag_pkg.sv
// Shared helpers for the complex magnitude-squared engine.
// CMAG_SAT_EN selects saturation (defined) or wrap-around (undefined) of out-of-range results.
package cmag_pkg;

    localparam int MAX_W = 64;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int fullW(input int width);
        return 2 * width;
    endfunction

    function automatic logic isOvf(input logic [MAX_W-1:0] full, input int outW);
        return (full >> outW) != '0;
    endfunction

    // Maps an exact sum onto outW bits: all-ones on overflow when saturating, low bits otherwise.
    function automatic logic [MAX_W-1:0] fitOut(input logic [MAX_W-1:0] full, input int outW);
        logic [MAX_W-1:0] mask;
        mask = (outW >= MAX_W) ? '1 : ((MAX_W'(1) << outW) - MAX_W'(1));
`ifdef CMAG_SAT_EN
        if (isOvf(full, outW)) return mask;
`endif
        return full & mask;
    endfunction

endpackage

// File: rtl/cmag_lane.sv
// One lane of the magnitude-squared pipeline: S1 operands, S2 squares, S3 result and overflow.
// The exact S2 sum is exposed combinationally so the top level can pick the strongest lane.
module cmag_lane
    import cmag_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OUT_W = 2 * WIDTH,
    localparam int FULL_W = fullW(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  logic              inValid,
    input  logic [WIDTH-1:0]  re,
    input  logic [WIDTH-1:0]  im,
    output logic [FULL_W-1:0] sum,
    output logic [OUT_W-1:0]  mag,
    output logic              ovf
);

    logic signed [WIDTH-1:0]  re1, im1;
    logic signed [FULL_W-1:0] reExt, imExt;
    logic [FULL_W-1:0]        reSq, imSq;

    assign reExt = FULL_W'(re1);
    assign imExt = FULL_W'(im1);
    // Cannot carry out: the largest sum is 2^(2*WIDTH-1).
    assign sum   = reSq + imSq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            re1  <= '0;
            im1  <= '0;
            reSq <= '0;
            imSq <= '0;
            mag  <= '0;
            ovf  <= 1'b0;
        end else if (adv) begin
            // Bubbles carry zero operands so idle outputs read as zero.
            re1  <= inValid ? re : '0;
            im1  <= inValid ? im : '0;
            reSq <= $unsigned(reExt * reExt);
            imSq <= $unsigned(imExt * imExt);
            mag  <= OUT_W'(fitOut(MAX_W'(sum), OUT_W));
            ovf  <= isOvf(MAX_W'(sum), OUT_W);
        end
    end

endmodule

// File: rtl/cmag_sq_argmax.sv
// N_CH-lane |x|^2 engine with strongest-lane report; three-stage pipeline with valid/ready on both sides.
// Define CMAG_SAT_EN to saturate results that do not fit in OUT_W bits instead of wrapping.
module cmag_sq_argmax
    import cmag_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N_CH  = 4,
    parameter int OUT_W = 2 * WIDTH,
    localparam int IDX_W  = clog2(N_CH),
    localparam int FULL_W = fullW(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_CH*WIDTH-1:0] in_re,
    input  logic [N_CH*WIDTH-1:0] in_im,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_CH*OUT_W-1:0] out_mag,
    output logic [N_CH-1:0]       out_ovf,
    output logic [IDX_W-1:0]      out_max_idx,
    output logic [OUT_W-1:0]      out_max_mag
);

    if (OUT_W < 1 || OUT_W > FULL_W) begin : gBadOutW
        $error("cmag_sq_argmax: OUT_W must lie in 1..2*WIDTH");
    end
    if (N_CH < 1) begin : gBadNch
        $error("cmag_sq_argmax: N_CH must be at least 1");
    end
    if (FULL_W > MAX_W) begin : gBadWidth
        $error("cmag_sq_argmax: 2*WIDTH exceeds the helper width");
    end

    // Handshake: a sample moves on a cycle where valid and ready are both high.
    // The whole pipeline advances together whenever the output slot is empty or being taken,
    // so in_ready depends combinationally on out_ready.
    logic adv;
    logic v1, v2;
    logic [FULL_W-1:0] laneSum [N_CH];
    logic [FULL_W-1:0] bestSum;
    logic [IDX_W-1:0]  bestIdx;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar c = 0; c < N_CH; c++) begin : gLane
        cmag_lane #(
            .WIDTH (WIDTH),
            .OUT_W (OUT_W)
        ) uLane (
            .clk     (clk),
            .rst     (rst),
            .adv     (adv),
            .inValid (in_valid),
            .re      (in_re[c*WIDTH +: WIDTH]),
            .im      (in_im[c*WIDTH +: WIDTH]),
            .sum     (laneSum[c]),
            .mag     (out_mag[c*OUT_W +: OUT_W]),
            .ovf     (out_ovf[c])
        );
    end

    // Exact sums are compared; strict greater-than keeps the lowest index on ties.
    always_comb begin
        bestIdx = '0;
        bestSum = laneSum[0];
        for (int c = 1; c < N_CH; c++) begin
            if (laneSum[c] > bestSum) begin
                bestSum = laneSum[c];
                bestIdx = IDX_W'(c);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            out_valid   <= 1'b0;
            out_max_idx <= '0;
            out_max_mag <= '0;
        end else if (adv) begin
            v1          <= in_valid;
            v2          <= v1;
            out_valid   <= v2;
            out_max_idx <= bestIdx;
            out_max_mag <= OUT_W'(fitOut(MAX_W'(bestSum), OUT_W));
        end
    end

endmodule

// File: tb/tb_cmag_sq_argmax.sv
// Bench for cmag_sq_argmax: a default 32-bit-output instance and a 24-bit-output instance share stimulus.
// Works with or without CMAG_SAT_EN defined.
module tb_cmag_sq_argmax;

    localparam int OW1 = 32;
    localparam int OW2 = 24;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        inValid, outReady;
    logic [63:0] inRe, inIm;

    logic        inReady1, outValid1;
    logic [127:0] mag1;
    logic [3:0]  ovf1;
    logic [1:0]  idx1;
    logic [31:0] max1;

    logic        inReady2, outValid2;
    logic [95:0] mag2;
    logic [3:0]  ovf2;
    logic [1:0]  idx2;
    logic [23:0] max2;

    logic [255:0] cur1, cur2;
    assign cur1 = 256'({max1, idx1, ovf1, mag1});
    assign cur2 = 256'({max2, idx2, ovf2, mag2});

    cmag_sq_argmax dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (inValid),
        .in_ready    (inReady1),
        .in_re       (inRe),
        .in_im       (inIm),
        .out_valid   (outValid1),
        .out_ready   (outReady),
        .out_mag     (mag1),
        .out_ovf     (ovf1),
        .out_max_idx (idx1),
        .out_max_mag (max1)
    );

    cmag_sq_argmax #(.OUT_W(OW2)) dutNarrow (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (inValid),
        .in_ready    (inReady2),
        .in_re       (inRe),
        .in_im       (inIm),
        .out_valid   (outValid2),
        .out_ready   (outReady),
        .out_mag     (mag2),
        .out_ovf     (ovf2),
        .out_max_idx (idx2),
        .out_max_mag (max2)
    );

    int checks = 0;
    int failures = 0;
    logic [255:0] exp1Q[$];
    logic [255:0] exp2Q[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact |x|^2 per lane in 64-bit integers, then fitted to ow bits.
    function automatic longint clip(input longint x, input int ow);
        longint lim;
        lim = longint'(1) << ow;
        if (x < lim) return x;
`ifdef CMAG_SAT_EN
        return lim - 1;
`else
        return x % lim;
`endif
    endfunction

    function automatic logic [255:0] refModel(input logic [63:0] re, input logic [63:0] im, input int ow);
        longint full [4];
        longint a, b, best;
        int bi;
        logic [255:0] r;
        best = -1;
        bi = 0;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a = longint'($signed(re[c*16 +: 16]));
            b = longint'($signed(im[c*16 +: 16]));
            full[c] = a * a + b * b;
            if (full[c] > best) begin
                best = full[c];
                bi = c;
            end
        end
        for (int c = 0; c < 4; c++) begin
            r |= 256'(clip(full[c], ow)) << (c * ow);
            if (full[c] >= (longint'(1) << ow)) r[4*ow + c] = 1'b1;
        end
        r |= 256'(bi) << (4*ow + 4);
        r |= 256'(clip(best, ow)) << (4*ow + 6);
        return r;
    endfunction

    function automatic logic [63:0] l16(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [127:0] l32(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    function automatic logic [15:0] randComp();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return 16'h8000;
        if (r == 1) return 16'h7fff;
        return 16'($urandom);
    endfunction

    function automatic logic [63:0] randVec();
        return {randComp(), randComp(), randComp(), randComp()};
    endfunction

    // Monitor / scoreboard, sampling on the falling edge.
    logic [255:0] prevOut;
    bit prevStall = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            prevStall = 1'b0;
        end else begin
            if (inValid && inReady1) begin
                exp1Q.push_back(refModel(inRe, inIm, OW1));
                exp2Q.push_back(refModel(inRe, inIm, OW2));
            end
            if (prevStall) check("stall_hold", cur1, prevOut);
            if (outValid1 && !outReady) check("stall_in_ready", 256'(inReady1), 256'(0));
            if (outValid1 && outReady) begin
                if (exp1Q.size() == 0) check("sb_unexpected1", 256'(exp1Q.size()), 256'(1));
                else check("sb_out1", cur1, exp1Q.pop_front());
            end
            if (outValid2 && outReady) begin
                if (exp2Q.size() == 0) check("sb_unexpected2", 256'(exp2Q.size()), 256'(1));
                else check("sb_out2", cur2, exp2Q.pop_front());
            end
            prevStall = outValid1 && !outReady;
            prevOut = cur1;
        end
    end

    // Driver: holds a sample until it transfers, bounded.
    task automatic send(input logic [63:0] re, input logic [63:0] im);
        bit acc;
        acc = 1'b0;
        inRe = re;
        inIm = im;
        inValid = 1'b1;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = inReady1;
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
        if (!acc) check("send_timeout", 256'(acc), 256'(1));
    endtask

    task automatic drain(input string name);
        outReady = 1'b1;
        for (int t = 0; t < 60 && (exp1Q.size() != 0 || exp2Q.size() != 0); t++) @(posedge clk);
        #1;
        check(name, 256'(exp1Q.size() + exp2Q.size()), 256'(0));
    endtask

    typedef struct {
        logic [63:0]  re;
        logic [63:0]  im;
        logic [127:0] mag;
        logic [3:0]   ovf;
        logic [1:0]   idx;
        logic [31:0]  maxMag;
    } vec_t;

    vec_t tab [5];

    // Single sample with exact latency: not valid after two edges, valid with results after three.
    task automatic applyVec(input vec_t v, input string name);
        outReady = 1'b1;
        send(v.re, v.im);
        @(posedge clk); #1;
        check({name, "_early"}, 256'(outValid1), 256'(0));
        @(posedge clk); #1;
        check({name, "_valid"}, 256'(outValid1), 256'(1));
        check({name, "_out"}, cur1, 256'({v.maxMag, v.idx, v.ovf, v.mag}));
        @(posedge clk); #1;
    endtask

    bit randDone;

    initial begin
        tab[0] = '{l16(3, -4, 0, -32768), l16(4, 3, -5, -32768),
                   l32(25, 25, 25, 32'h80000000), 4'd0, 2'd3, 32'h80000000};
        tab[1] = '{l16(1, 1, 1, 1), l16(-1, -1, -1, -1), l32(2, 2, 2, 2), 4'd0, 2'd0, 32'd2};
        tab[2] = '{64'd0, 64'd0, 128'd0, 4'd0, 2'd0, 32'd0};
        tab[3] = '{l16(10, 0, -12, 13), l16(0, -11, 5, 0), l32(100, 121, 169, 169), 4'd0, 2'd2, 32'd169};
        tab[4] = '{l16(32767, 0, 0, -32768), l16(-32768, 0, 0, 0),
                   l32(32'h7fff0001, 0, 0, 32'h40000000), 4'd0, 2'd0, 32'h7fff0001};

        inValid = 1'b0;
        outReady = 1'b1;
        inRe = '0;
        inIm = '0;

        // Reset held with random inputs.
        repeat (3) begin
            @(posedge clk); #1;
            inValid = 1'($urandom_range(0, 1));
            inRe = randVec();
            inIm = randVec();
            outReady = 1'($urandom_range(0, 1));
            #1;
            check("rst_valid", 256'(outValid1), 256'(0));
            check("rst_out1", cur1, 256'(0));
            check("rst_out2", cur2, 256'(0));
            check("rst_in_ready", 256'(inReady1), 256'(1));
        end
        inValid = 1'b0;
        outReady = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("idle_valid", 256'(outValid1), 256'(0));
            check("idle_out", cur1, 256'(0));
        end

        // Directed vectors.
        for (int i = 0; i < 5; i++) applyVec(tab[i], $sformatf("vec%0d", i));
        drain("drain_vec");

        // Overflow on the 24-bit instance.
        send(l16(-32768, 100, 0, 0), l16(-32768, 0, 0, 0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("ovf_valid", 256'(outValid2), 256'(1));
        check("ovf_flag", 256'(ovf2), 256'(4'b0001));
        check("ovf_idx", 256'(idx2), 256'(0));
`ifdef CMAG_SAT_EN
        check("ovf_mag", 256'(mag2), 256'({24'd0, 24'd0, 24'd10000, 24'hffffff}));
        check("ovf_max", 256'(max2), 256'(24'hffffff));
`else
        check("ovf_mag", 256'(mag2), 256'({24'd0, 24'd0, 24'd10000, 24'h000000}));
        check("ovf_max", 256'(max2), 256'(24'h000000));
`endif
        drain("drain_ovf");

        // Back-to-back stream with a four-cycle output stall.
        fork
            begin
                for (int i = 0; i < 8; i++) send(l16(i + 1, -i, 3 * i, 100 - i), l16(i, 2, -i, i * 7));
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                outReady = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("bp_in_ready", 256'(inReady1), 256'(0));
                    @(posedge clk);
                end
                #1;
                outReady = 1'b1;
            end
        join
        drain("drain_bp");

        // Random traffic with random backpressure.
        randDone = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    send(randVec(), randVec());
                end
                randDone = 1'b1;
            end
            begin
                while (!randDone) begin
                    @(posedge clk); #1;
                    outReady = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain("drain_rand");

        // Reset with three samples in flight.
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) send(l16(5 + i, 6, 7, 8), l16(1, 2, 3, 4 + i));
        rst = 1'b0;
        exp1Q.delete();
        exp2Q.delete();
        #1;
        check("midrst_valid1", 256'(outValid1), 256'(0));
        check("midrst_valid2", 256'(outValid2), 256'(0));
        check("midrst_out", cur1, 256'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("midrst_stale", 256'(outValid1), 256'(0));
        end
        applyVec(tab[0], "post_rst");
        drain("drain_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
